mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares one memory_unit instance between the instruction-fetch path and the load/store path. This enables a unified instruction/data memory in place of the separate instruction and data memories. Each cycle it grants at most one access, drives the shared memory port combinationally from the winner, and registers read data back to the winner with a fixed one-cycle latency. The default policy is fixed priority with data first; an optional starvation guard bounds fetch wait time.

## Interface
Parameters:
- ADDRSIZE, 8: memory address width (256 entries)
- WORDSIZE, 64: data width
- MAXWAIT, 4: consecutive denied fetch cycles before fetch is forced (guard only), range 1..15

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, held with if_addr until if_gnt
- if_addr  in  ADDRSIZE  fetch address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  WORDSIZE  fetch data
- d_req  in  1  data request, held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDRSIZE  data address
- d_wdata  in  WORDSIZE  write data
- d_gnt  out  1  data access accepted this cycle
- d_rvalid  out  1  data read result valid (reads only)
- d_rdata  out  WORDSIZE  data read result
- mem_rden  out  1  memory read enable
- mem_wren  out  1  memory write enable
- mem_addr  out  ADDRSIZE  memory address
- mem_d  out  WORDSIZE  memory write data
- mem_q  in  WORDSIZE  memory read data, combinational from mem_addr

## Operation
- Arbitration is combinational per cycle:
  - d_req alone → data wins.
  - if_req alone → fetch wins.
  - Both → data wins, unless the starvation guard forces fetch.
- Winner's gnt = 1 in the same cycle. Loser's gnt = 0; the loser keeps its request asserted.
- Memory port, fetch winner: mem_rden=1, mem_wren=0, mem_addr=if_addr.
- Memory port, data read winner: mem_rden=1, mem_addr=d_addr.
- Memory port, data write winner: mem_wren=1, mem_rden=0, mem_addr=d_addr, mem_d=d_wdata.
- Memory port, no winner: mem_rden=mem_wren=0, mem_addr=0, mem_d=0.
- Response registers. At the posedge ending a read grant, mem_q is captured into the winner's rdata register, and that winner's rvalid is set for exactly one cycle.
- rdata registers hold their value until the next read to the same port. rvalid is cleared the following cycle unless a new read of the same port was granted.
- Writes complete at the posedge ending the d_gnt cycle. No d_rvalid is produced for a write.
- Internal state: resp_sel (NONE/IF/D, registers which port owns the pending response) and wait counter wcnt (4 bits).
- Reset values: if_rvalid=0, d_rvalid=0, if_rdata=0, d_rdata=0, resp_sel=NONE, wcnt=0.
- While rst=0: all gnt outputs and mem_rden/mem_wren are forced to 0.

## Timing
- Grant latency: 0 cycles (same cycle as request when the arbiter is uncontended).
- Read latency: rvalid/rdata valid in cycle N+1 for a grant in cycle N.
- Throughput: one access per cycle. Back-to-back grants to either port are legal; rvalid stays high across consecutive reads of the same port.
- Data-then-fetch alternation: the d_rvalid and if_rvalid pulses are in consecutive cycles, never both high in the same cycle.
- Reset asserted mid-access: the pending rvalid is dropped and the response is lost. Requesters must reissue after reset.
- Requests arriving in the release cycle of reset are arbitrated normally.

## Configuration
- Macro ARB_STARVE_GUARD_EN.
- Defined:
  - wcnt increments (saturating at 15) on each cycle with if_req=1 and if_gnt=0.
  - wcnt clears on if_gnt, or when if_req=0.
  - When wcnt ≥ MAXWAIT and if_req=1, fetch wins even if d_req=1. d_gnt=0 that cycle.
- Not defined:
  - Strict data priority. wcnt is absent.
  - Fetch can starve indefinitely under continuous d_req.

## Test plan
- Uncontended fetch: if_req=1, if_addr=0x10, mem holds 0xDEAD at 0x10 → if_gnt=1 and mem_rden=1 same cycle; next cycle if_rvalid=1, if_rdata=0xDEAD.
- Data write, then read: d_we=1, d_addr=0x20, d_wdata=0x1234 granted; next cycle d_we=0 read of 0x20 → d_rvalid=1, d_rdata=0x1234 the cycle after; no d_rvalid after the write.
- Contention: if_req and d_req both high in cycle 0 → d_gnt=1, if_gnt=0; cycle 1 (d_req dropped) → if_gnt=1; cycle 2 → if_rvalid=1.
- Starvation, macro on, MAXWAIT=4: d_req held 10 cycles with if_req high → if_gnt=1 in cycle 4 with d_gnt=0; wcnt returns to 0. Macro off → if_gnt=0 for all 10 cycles.
- Reset mid-read: grant a d read, assert rst=0 before the next posedge → d_rvalid=0, d_rdata=0, no gnt while in reset; the first request after release is served normally.
- Back-to-back fetch at addresses 0,1,2 → if_gnt high 3 cycles; if_rvalid high cycles 1–3 with data in address order.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between fetch and load/store.
// Optional fetch starvation guard is enabled with `define ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int ADDRSIZE = 8,
  parameter int WORDSIZE = 64,
  parameter int MAXWAIT  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDRSIZE-1:0] if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [WORDSIZE-1:0] if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDRSIZE-1:0] d_addr,
  input  logic [WORDSIZE-1:0] d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [WORDSIZE-1:0] d_rdata,
  output logic                mem_rden,
  output logic                mem_wren,
  output logic [ADDRSIZE-1:0] mem_addr,
  output logic [WORDSIZE-1:0] mem_d,
  input  logic [WORDSIZE-1:0] mem_q
);

  typedef enum logic [1:0] {SEL_NONE, SEL_IF, SEL_D} sel_t;

  sel_t resp_sel, resp_nxt;
  logic if_win, d_win, force_if;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] wcnt;

  assign force_if = if_req && (wcnt >= 4'(MAXWAIT));

  // Counts consecutive denied fetch cycles; any fetch grant or idle fetch clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   wcnt <= '0;
    else if (!if_req || if_win) wcnt <= '0;
    else if (wcnt != 4'hF)      wcnt <= wcnt + 4'd1;
  end
`else
  assign force_if = 1'b0;
`endif

  // Reset gates both winners so the memory port and grants stay idle in reset.
  always_comb begin
    d_win  = rst && d_req && !force_if;
    if_win = rst && if_req && !d_win;
  end

  always_comb begin
    if_gnt   = if_win;
    d_gnt    = d_win;
    mem_rden = if_win || (d_win && !d_we);
    mem_wren = d_win && d_we;
    mem_addr = '0;
    mem_d    = '0;
    if (if_win) begin
      mem_addr = if_addr;
    end else if (d_win) begin
      mem_addr = d_addr;
      if (d_we) mem_d = d_wdata;
    end
  end

  always_comb begin
    resp_nxt = SEL_NONE;
    if (if_win)              resp_nxt = SEL_IF;
    else if (d_win && !d_we) resp_nxt = SEL_D;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_sel <= SEL_NONE;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      resp_sel <= resp_nxt;
      if (resp_nxt == SEL_IF) if_rdata <= mem_q;
      if (resp_nxt == SEL_D)  d_rdata  <= mem_q;
    end
  end

  assign if_rvalid = (resp_sel == SEL_IF);
  assign d_rvalid  = (resp_sel == SEL_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed literal checks plus randomized traffic
// against a spec-level model with its own reference memory.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 64;
  localparam int MW = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_rden, mem_wren;
  logic [DW-1:0] if_rdata, d_rdata, mem_d, mem_q;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] env_mem [0:255];
  logic [DW-1:0] ref_mem [0:255];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDRSIZE(AW), .WORDSIZE(DW), .MAXWAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr),
    .mem_d(mem_d), .mem_q(mem_q)
  );

  // Shared memory unit: combinational read, write at posedge.
  assign mem_q = env_mem[mem_addr];
  always @(posedge clk) if (mem_wren) env_mem[mem_addr] <= mem_d;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: expected registered responses and fetch wait length.
  bit            m_if_rv = 0, m_d_rv = 0, m_if_gnt = 0, m_d_gnt = 0;
  logic [DW-1:0] m_if_rd = '0, m_d_rd = '0;
  int            waited = 0;
  bit            frc, dw, iw;
  logic [AW-1:0] e_addr;

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_if_gnt", if_gnt, 0);
      check("rst_d_gnt", d_gnt, 0);
      check("rst_rden", mem_rden, 0);
      check("rst_wren", mem_wren, 0);
      check("rst_if_rvalid", if_rvalid, 0);
      check("rst_d_rvalid", d_rvalid, 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      m_if_rv = 0; m_d_rv = 0; m_if_rd = '0; m_d_rd = '0;
      m_if_gnt = 0; m_d_gnt = 0; waited = 0;
    end else begin
      frc = GUARD && if_req && (waited >= MW);
      dw  = d_req && !frc;
      iw  = if_req && !dw;
      m_if_gnt = iw; m_d_gnt = dw;
      e_addr = iw ? if_addr : (dw ? d_addr : '0);
      check("if_gnt", if_gnt, iw);
      check("d_gnt", d_gnt, dw);
      check("mem_rden", mem_rden, iw || (dw && !d_we));
      check("mem_wren", mem_wren, dw && d_we);
      check("mem_addr", mem_addr, e_addr);
      if (dw && d_we)  check("mem_d", mem_d, d_wdata);
      if (!iw && !dw)  check("mem_d_idle", mem_d, 0);
      check("if_rvalid", if_rvalid, m_if_rv);
      check("if_rdata", if_rdata, m_if_rd);
      check("d_rvalid", d_rvalid, m_d_rv);
      check("d_rdata", d_rdata, m_d_rd);
      check("rvalid_excl", if_rvalid && d_rvalid, 0);
      m_if_rv = iw;
      if (iw) m_if_rd = ref_mem[if_addr];
      m_d_rv = dw && !d_we;
      if (m_d_rv) m_d_rd = ref_mem[d_addr];
      if (dw && d_we) ref_mem[d_addr] = d_wdata;
      waited = (if_req && !iw) ? ((waited < 15) ? waited + 1 : 15) : 0;
    end
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  logic [DW-1:0] v;
  bit            exp_if;

  initial begin
    for (int i = 0; i < 256; i++) begin
      v = {$urandom, $urandom};
      env_mem[i] = v; ref_mem[i] = v;
    end
    env_mem[8'h10] = 64'hDEAD; ref_mem[8'h10] = 64'hDEAD;
    for (int i = 0; i < 3; i++) begin
      env_mem[i] = 64'hA0 + 64'(i); ref_mem[i] = 64'hA0 + 64'(i);
    end
    repeat (2) step;
    rst = 1'b1;

    // Uncontended fetch
    if_req = 1; if_addr = 8'h10;
    @(negedge clk);
    check("t1_if_gnt", if_gnt, 1);
    check("t1_rden", mem_rden, 1);
    step; if_req = 0;
    @(negedge clk);
    check("t1_if_rvalid", if_rvalid, 1);
    check("t1_if_rdata", if_rdata, 64'hDEAD);

    // Write then read back
    step; d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 64'h1234;
    @(negedge clk);
    check("t2_wr_gnt", d_gnt, 1);
    check("t2_wren", mem_wren, 1);
    step; d_we = 0;
    @(negedge clk);
    check("t2_no_rv_after_wr", d_rvalid, 0);
    check("t2_rd_gnt", d_gnt, 1);
    step; d_req = 0;
    @(negedge clk);
    check("t2_d_rvalid", d_rvalid, 1);
    check("t2_d_rdata", d_rdata, 64'h1234);

    // Contention: data first, then fetch
    step; if_req = 1; if_addr = 8'h10; d_req = 1; d_we = 0; d_addr = 8'h20;
    @(negedge clk);
    check("t3_d_gnt", d_gnt, 1);
    check("t3_if_gnt", if_gnt, 0);
    step; d_req = 0;
    @(negedge clk);
    check("t3_if_gnt_c1", if_gnt, 1);
    check("t3_d_rvalid_c1", d_rvalid, 1);
    step; if_req = 0;
    @(negedge clk);
    check("t3_if_rvalid_c2", if_rvalid, 1);
    check("t3_d_rvalid_c2", d_rvalid, 0);
    check("t3_if_rdata", if_rdata, 64'hDEAD);

    // Starvation under continuous data reads
    step; if_req = 1; d_req = 1; d_we = 0; d_addr = 8'h20;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp_if = GUARD && (i == 4 || i == 9);
      check("t4_if_gnt", if_gnt, exp_if);
      check("t4_d_gnt", d_gnt, !exp_if);
      step;
    end
    if_req = 0; d_req = 0;

    // Reset during a granted data read
    step; d_req = 1; d_we = 0; d_addr = 8'h20;
    @(negedge clk);
    check("t5_d_gnt", d_gnt, 1);
    #1 rst = 0;
    @(negedge clk);
    check("t5_rst_d_rvalid", d_rvalid, 0);
    check("t5_rst_d_rdata", d_rdata, 0);
    check("t5_rst_d_gnt", d_gnt, 0);
    step; rst = 1;
    @(negedge clk);
    check("t5_post_gnt", d_gnt, 1);
    step; d_req = 0;
    @(negedge clk);
    check("t5_post_rvalid", d_rvalid, 1);
    check("t5_post_rdata", d_rdata, 64'h1234);

    // Back-to-back fetch 0,1,2
    step; if_req = 1;
    for (int k = 0; k < 3; k++) begin
      if_addr = 8'(k);
      @(negedge clk);
      check("t6_if_gnt", if_gnt, 1);
      if (k > 0) begin
        check("t6_if_rvalid", if_rvalid, 1);
        check("t6_if_rdata", if_rdata, 64'hA0 + 64'(k - 1));
      end
      step;
    end
    if_req = 0;
    @(negedge clk);
    check("t6_if_rvalid_last", if_rvalid, 1);
    check("t6_if_rdata_last", if_rdata, 64'hA2);

    // Randomized traffic; requests held until the model says they were granted
    step;
    for (int n = 0; n < 3000; n++) begin
      if (!if_req || m_if_gnt) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = 8'($urandom_range(0, 31));
      end
      if (!d_req || m_d_gnt) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = ($urandom_range(0, 1) != 0);
        d_addr  = 8'($urandom_range(0, 31));
        d_wdata = {$urandom, $urandom};
      end
      rst = ($urandom_range(0, 199) != 0);
      step;
    end
    rst = 1; if_req = 0; d_req = 0;
    repeat (2) step;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
